// File: rtl/gshare_bp_pkg.sv
// Shared definitions for the gshare branch predictor: default sizes and the
// saturating-counter helpers used by the counter table.
package gshare_bp_pkg;

  localparam int IDX_W_DEF  = 8;
  localparam int CNT_W_DEF  = 2;
  localparam int HIST_W_DEF = 8;

  // Counters are at most 4 bits wide, so the helpers work on a 4-bit container
  // and callers narrow the result to their own CNT_W.
  localparam int CNT_MAX_W = 4;

  // Weakly-taken value: MSB set, all other bits clear.
  function automatic logic [CNT_MAX_W-1:0] cnt_reset_val(input int cnt_w);
    return CNT_MAX_W'(1 << (cnt_w - 1));
  endfunction

  // One saturating step toward taken (up=1) or not-taken (up=0); never wraps.
  function automatic logic [CNT_MAX_W-1:0] cnt_sat_step(input logic [CNT_MAX_W-1:0] cnt,
                                                        input logic up,
                                                        input int cnt_w);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = CNT_MAX_W'((1 << cnt_w) - 1);
    if (up) begin
      return (cnt == max_v) ? cnt : cnt + 1'b1;
    end
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

endpackage

// File: rtl/gshare_bp_if.sv
// Fetch/commit bus between the front end / ROB (master) and the predictor
// (slave).
//
// Handshake: there is no backpressure. rdy is a global enable driven by the
// master side; a fetch is accepted in any cycle with in_fetch_valid=1 and
// rdy=1, and a commit in any cycle with in_commit_valid=1 and rdy=1 (rst wins
// over both). out_fetch_taken / out_fetch_hist are combinational and valid
// every cycle.
interface gshare_bp_if #(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8
);
  logic              rdy;
  logic              in_fetch_valid;
  logic [IDX_W-1:0]  in_fetch_idx;
  logic              in_fetch_taken;
  logic              out_fetch_taken;
  logic [HIST_W-1:0] out_fetch_hist;
  logic              in_commit_valid;
  logic [IDX_W-1:0]  in_commit_idx;
  logic [HIST_W-1:0] in_commit_hist;
  logic              in_commit_taken;
  logic              in_commit_mispredict;

  modport master (
    output rdy, in_fetch_valid, in_fetch_idx, in_fetch_taken,
    output in_commit_valid, in_commit_idx, in_commit_hist,
    output in_commit_taken, in_commit_mispredict,
    input  out_fetch_taken, out_fetch_hist
  );

  modport slave (
    input  rdy, in_fetch_valid, in_fetch_idx, in_fetch_taken,
    input  in_commit_valid, in_commit_idx, in_commit_hist,
    input  in_commit_taken, in_commit_mispredict,
    output out_fetch_taken, out_fetch_hist
  );
endinterface

// File: rtl/bp_sat_counter_table.sv
// Table of 2**IDX_W saturating counters: one combinational read port for the
// prediction and one write port that applies a saturating step in place.
// A read and a write to the same entry in one cycle returns the old value.
module bp_sat_counter_table
  import gshare_bp_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_up
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_reset_val(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] wr_next;

  assign rd_cnt = cnt_q[rd_idx];

  // Next value of the written entry: one saturating step in the resolved direction.
  always_comb begin
    wr_next = CNT_W'(cnt_sat_step(CNT_MAX_W'(cnt_q[wr_idx]), wr_up, CNT_W));
  end

  // Reset every entry to weakly taken; otherwise update the single written entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= RST_VAL;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_next;
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// Gshare branch direction predictor with speculative global history and
// commit-time repair on mispredict.
// Build option: define BP_GSHARE_EN to XOR the history into the table index;
// without it the PC tag indexes the table directly (history is still kept and
// exported so the port list does not change).
module gshare_bp
  import gshare_bp_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int HIST_W = HIST_W_DEF
) (
  input logic         clk,
  input logic         rst,
  gshare_bp_if.slave  bus
);

  logic [HIST_W-1:0] spec_ghr;
  logic [HIST_W-1:0] fetch_shift;
  logic [HIST_W-1:0] repair_hist;
  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  commit_idx;
  logic [CNT_W-1:0]  rd_cnt;
  logic              fetch_fire;
  logic              commit_fire;
  logic              repair;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  assign fetch_fire  = bus.rdy & bus.in_fetch_valid;
  assign commit_fire = bus.rdy & bus.in_commit_valid;
  // Mispredict only matters on a real commit.
  assign repair      = commit_fire & bus.in_commit_mispredict;

  // History with the newest direction inserted at the LSB.
  if (HIST_W == 1) begin : g_hist1
    assign fetch_shift = bus.in_fetch_taken;
    assign repair_hist = bus.in_commit_taken;
  end else begin : g_histn
    assign fetch_shift = {spec_ghr[HIST_W-2:0], bus.in_fetch_taken};
    assign repair_hist = {bus.in_commit_hist[HIST_W-2:0], bus.in_commit_taken};
  end

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] commit_hist_ext;

  // Zero-extend both histories to the index width and fold them into the PC tag.
  always_comb begin
    ghr_ext                     = '0;
    ghr_ext[HIST_W-1:0]         = spec_ghr;
    commit_hist_ext             = '0;
    commit_hist_ext[HIST_W-1:0] = bus.in_commit_hist;
    fetch_idx                   = bus.in_fetch_idx ^ ghr_ext;
    commit_idx                  = bus.in_commit_idx ^ commit_hist_ext;
  end
`else
  // Plain bimodal indexing: the PC tag selects the counter directly.
  always_comb begin
    fetch_idx  = bus.in_fetch_idx;
    commit_idx = bus.in_commit_idx;
  end
`endif

  bp_sat_counter_table #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (fetch_idx),
    .rd_cnt (rd_cnt),
    .wr_en  (commit_fire),
    .wr_idx (commit_idx),
    .wr_up  (bus.in_commit_taken)
  );

  assign bus.out_fetch_taken = rd_cnt[CNT_W-1];
  assign bus.out_fetch_hist  = spec_ghr;

  // Speculative history: repair from the commit beats a same-cycle fetch shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr <= '0;
    end else if (repair) begin
      spec_ghr <= repair_hist;
    end else if (fetch_fire) begin
      spec_ghr <= fetch_shift;
    end
  end

  // Commit statistics, free-running modulo 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (commit_fire) begin
      if (bus.in_commit_mispredict) begin
        miss_cnt <= miss_cnt + 32'd1;
      end else begin
        hit_cnt <= hit_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp with default sizes (IDX_W=8, CNT_W=2, HIST_W=8).
// Expectations that depend on the indexing mode follow BP_GSHARE_EN.
module tb_gshare_bp;

  logic clk;
  logic rst;

  int checks;
  int errors;

  gshare_bp_if #(.IDX_W(8), .HIST_W(8)) bus ();

  gshare_bp #(.IDX_W(8), .CNT_W(2), .HIST_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table entry addressed by a tag/history pair in the current build mode.
  function automatic int eidx(input int tag, input int hist);
`ifdef BP_GSHARE_EN
    return (tag ^ hist) & 8'hff;
`else
    return tag & 8'hff;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    bus.rdy                  = 1'b1;
    bus.in_fetch_valid       = 1'b0;
    bus.in_fetch_idx         = '0;
    bus.in_fetch_taken       = 1'b0;
    bus.in_commit_valid      = 1'b0;
    bus.in_commit_idx        = '0;
    bus.in_commit_hist       = '0;
    bus.in_commit_taken      = 1'b0;
    bus.in_commit_mispredict = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_c[4];
  int k;

  initial begin
    checks = 0;
    errors = 0;
    exp_c  = '{1, 0, 0, 0};
    idle();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state and first lookup at 0x05
    bus.in_fetch_idx = 8'h05;
    #1;
    check("rst_pred", 32'(bus.out_fetch_taken), 32'd1);
    check("rst_hist", 32'(bus.out_fetch_hist), 32'h00);
    check("rst_hit", dut.hit_cnt, 32'd0);
    check("rst_miss", dut.miss_cnt, 32'd0);
    check("rst_cnt5", 32'(dut.u_table.cnt_q[5]), 32'd2);

    // Four not-taken commits to 0x05 with hist 0: 2 -> 1 -> 0 -> 0 -> 0
    for (int i = 0; i < 4; i++) begin
      bus.in_commit_valid = 1'b1;
      bus.in_commit_idx   = 8'h05;
      bus.in_commit_hist  = 8'h00;
      bus.in_commit_taken = 1'b0;
      tick();
      bus.in_commit_valid = 1'b0;
      check("sat_dn_cnt", 32'(dut.u_table.cnt_q[5]), 32'(exp_c[i]));
    end
    bus.in_fetch_idx = 8'h05;
    #1;
    check("sat_dn_pred", 32'(bus.out_fetch_taken), 32'd0);
    check("sat_dn_hit", dut.hit_cnt, 32'd4);

    // Three fetches taken 1,0,1 -> history 0x01, 0x02, 0x05
    bus.in_fetch_valid = 1'b1;
    bus.in_fetch_taken = 1'b1; tick();
    check("ghr_1", 32'(bus.out_fetch_hist), 32'h01);
    bus.in_fetch_taken = 1'b0; tick();
    check("ghr_2", 32'(bus.out_fetch_hist), 32'h02);
    bus.in_fetch_taken = 1'b1; tick();
    check("ghr_5", 32'(bus.out_fetch_hist), 32'h05);
    bus.in_fetch_valid = 1'b0;
    bus.in_fetch_idx   = 8'h05;
    #1;
`ifdef BP_GSHARE_EN
    // 0x05 ^ 0x05 reads untouched entry 0x00 (weakly taken)
    check("xor_pred", 32'(bus.out_fetch_taken), 32'd1);
`else
    // Direct index reads the saturated entry 0x05
    check("xor_pred", 32'(bus.out_fetch_taken), 32'd0);
`endif

    // Fetch taken=1 plus mispredicted commit hist=0x03 taken=0: repair wins
    bus.in_fetch_valid       = 1'b1;
    bus.in_fetch_taken       = 1'b1;
    bus.in_commit_valid      = 1'b1;
    bus.in_commit_idx        = 8'h10;
    bus.in_commit_hist       = 8'h03;
    bus.in_commit_taken      = 1'b0;
    bus.in_commit_mispredict = 1'b1;
    tick();
    idle();
    check("repair_ghr", 32'(bus.out_fetch_hist), 32'h06);
    check("repair_miss", dut.miss_cnt, 32'd1);
    check("repair_hit", dut.hit_cnt, 32'd4);
    k = eidx(8'h10, 8'h03);
    check("repair_cnt", 32'(dut.u_table.cnt_q[k]), 32'd1);

    // Same entry (holding 1) fetched and committed taken in one cycle
    bus.in_fetch_valid  = 1'b1;
    bus.in_fetch_taken  = 1'b0;
    bus.in_fetch_idx    = 8'(eidx(k, 8'h06));
    bus.in_commit_valid = 1'b1;
    bus.in_commit_idx   = 8'h10;
    bus.in_commit_hist  = 8'h03;
    bus.in_commit_taken = 1'b1;
    #1;
    check("bypass_old", 32'(bus.out_fetch_taken), 32'd0);
    tick();
    idle();
    // History is now 0x0C; point the fetch back at the same entry
    bus.in_fetch_idx = 8'(eidx(k, 8'h0c));
    #1;
    check("bypass_new", 32'(bus.out_fetch_taken), 32'd1);
    check("bypass_cnt", 32'(dut.u_table.cnt_q[k]), 32'd2);
    check("bypass_ghr", 32'(bus.out_fetch_hist), 32'h0c);
    check("bypass_hit", dut.hit_cnt, 32'd5);

    // rdy low: nothing may change
    bus.rdy                  = 1'b0;
    bus.in_fetch_valid       = 1'b1;
    bus.in_fetch_taken       = 1'b1;
    bus.in_commit_valid      = 1'b1;
    bus.in_commit_idx        = 8'h05;
    bus.in_commit_hist       = 8'h00;
    bus.in_commit_taken      = 1'b1;
    bus.in_commit_mispredict = 1'b1;
    repeat (2) tick();
    idle();
    check("hold_ghr", 32'(bus.out_fetch_hist), 32'h0c);
    check("hold_cnt5", 32'(dut.u_table.cnt_q[5]), 32'd0);
    check("hold_hit", dut.hit_cnt, 32'd5);
    check("hold_miss", dut.miss_cnt, 32'd1);

    // Mispredict without commit_valid is ignored
    bus.in_commit_hist       = 8'h03;
    bus.in_commit_taken      = 1'b1;
    bus.in_commit_mispredict = 1'b1;
    tick();
    idle();
    check("novalid_ghr", 32'(bus.out_fetch_hist), 32'h0c);
    check("novalid_miss", dut.miss_cnt, 32'd1);

    // Three taken commits to 0x05: 0 -> 1 -> 2 -> 3, then saturate at 3
    for (int i = 0; i < 4; i++) begin
      bus.in_commit_valid = 1'b1;
      bus.in_commit_idx   = 8'h05;
      bus.in_commit_taken = 1'b1;
      tick();
    end
    idle();
    check("sat_up_cnt", 32'(dut.u_table.cnt_q[5]), 32'd3);
    check("sat_up_hit", dut.hit_cnt, 32'd9);

    // Reset mid-operation with a pending repair
    rst                      = 1'b1;
    bus.in_fetch_valid       = 1'b1;
    bus.in_fetch_taken       = 1'b1;
    bus.in_commit_valid      = 1'b1;
    bus.in_commit_idx        = 8'h05;
    bus.in_commit_hist       = 8'h7f;
    bus.in_commit_taken      = 1'b1;
    bus.in_commit_mispredict = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    bus.in_fetch_idx = 8'h05;
    #1;
    check("rst2_ghr", 32'(bus.out_fetch_hist), 32'h00);
    check("rst2_pred", 32'(bus.out_fetch_taken), 32'd1);
    check("rst2_cnt5", 32'(dut.u_table.cnt_q[5]), 32'd2);
    check("rst2_cntk", 32'(dut.u_table.cnt_q[k]), 32'd2);
    check("rst2_hit", dut.hit_cnt, 32'd0);
    check("rst2_miss", dut.miss_cnt, 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
